// File: rtl/axis_dsnk_chk.sv
// axis_dsnk_chk
// AXI-stream sink/checker. It accepts words under a rotating TREADY mask and
// compares each accepted word with a free-running up/down counter sequence.
// It also checks TLAST against the programmed packet length. Counters, sticky
// error flags and a first-mismatch capture are exposed through a
// cmd/new_cmd/stat register interface.
module axis_dsnk_chk #(
    parameter int C_S_AXIS_TDATA_NUM_BYTES = 4,
    parameter int C_ERR_STOP               = 0
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESET,
    input  logic                                  S_AXIS_TVALID,
    input  logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
    input  logic                                  S_AXIS_TLAST,
    output logic                                  S_AXIS_TREADY,
    input  logic [31:0]                           cmd,
    input  logic                                  new_cmd,
    input  logic [31:0]                           num_bytes,
    input  logic [31:0]                           data_type,
    input  logic [31:0]                           num_pkts,
    input  logic [31:0]                           rdy_pattern,
    output logic [31:0]                           stat,
    output logic [31:0]                           rx_cnt,
    output logic [31:0]                           pkt_cnt,
    output logic [31:0]                           err_cnt,
    output logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] first_err_exp,
    output logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] first_err_got
);

    localparam int          NB   = C_S_AXIS_TDATA_NUM_BYTES;
    localparam int          W    = 8 * NB;
    localparam logic [31:0] NB32 = 32'(NB);

    // Control state: enable_q=0 is IDLE, enable_q=1 & !done_q is RUN,
    // done_q=1 is DONE. done_q survives a disable and only clear/reset drop it.
    logic          enable_q, enable_d;
    logic          done_q,   done_d;
    logic [31:0]   rot_q,    rot_d;
    logic [W-1:0]  exp_q,    exp_d;
    logic [31:0]   wcnt_q,   wcnt_d;
    logic [31:0]   rx_q,     rx_d;
    logic [31:0]   pkt_q,    pkt_d;
    logic [31:0]   err_q,    err_d;
    logic          dseen_q,  dseen_d;
    logic          lseen_q,  lseen_d;
    logic [W-1:0]  fexp_q,   fexp_d;
    logic [W-1:0]  fgot_q,   fgot_d;

    logic          cmd_en, cmd_clr, cmd_dis;
    logic          xfr, count_ok;
    logic          data_err, last_err, last_exp;
    logic          complete, stop;
    logic [32:0]   wsum;
    logic [31:0]   pkt_next;
    logic          unused_tstrb;

    // Byte strobes are accepted but not checked.
    assign unused_tstrb = ^S_AXIS_TSTRB;

    assign cmd_en  = new_cmd && (cmd == 32'd1);
    assign cmd_clr = new_cmd && (cmd == 32'd2);
    assign cmd_dis = new_cmd && (cmd == 32'd3);

    assign S_AXIS_TREADY = enable_q & ~done_q & rot_q[0];
    assign xfr           = S_AXIS_TVALID & S_AXIS_TREADY;
    // A handshake that coincides with clear/disable completes on the bus but is
    // deliberately left out of all bookkeeping.
    assign count_ok      = xfr & ~cmd_clr & ~cmd_dis;

    // 33-bit sum so a huge wcnt can never wrap below num_bytes.
    assign wsum     = {1'b0, wcnt_q} + {1'b0, NB32};
    assign last_exp = (wsum >= {1'b0, num_bytes});
    assign data_err = count_ok && (S_AXIS_TDATA != exp_q);
    assign last_err = count_ok && (S_AXIS_TLAST != last_exp);
    assign pkt_next = pkt_q + 32'd1;
    assign complete = count_ok && S_AXIS_TLAST && (num_pkts != 32'd0) && (pkt_next == num_pkts);
    assign stop     = complete || ((C_ERR_STOP != 0) && (data_err || last_err));

    // Next-state: command handling, backpressure rotation and per-word checks.
    always_comb begin
        enable_d = enable_q;
        done_d   = done_q;
        rot_d    = rot_q;
        exp_d    = exp_q;
        wcnt_d   = wcnt_q;
        rx_d     = rx_q;
        pkt_d    = pkt_q;
        err_d    = err_q;
        dseen_d  = dseen_q;
        lseen_d  = lseen_q;
        fexp_d   = fexp_q;
        fgot_d   = fgot_q;
        if (cmd_clr) begin
            enable_d = 1'b0;
            done_d   = 1'b0;
            rot_d    = rdy_pattern;
            exp_d    = '0;
            wcnt_d   = '0;
            rx_d     = '0;
            pkt_d    = '0;
            err_d    = '0;
            dseen_d  = 1'b0;
            lseen_d  = 1'b0;
            fexp_d   = '0;
            fgot_d   = '0;
        end else begin
            if (cmd_dis) begin
                enable_d = 1'b0;
            end else if (stop) begin
                enable_d = 1'b0;
            end else if (cmd_en && !done_q) begin
                enable_d = 1'b1;
            end
            if (stop) begin
                done_d = 1'b1;
            end

            if (cmd_en && !done_q) begin
                rot_d = rdy_pattern;
            end else if (enable_q && !done_q) begin
                rot_d = {rot_q[0], rot_q[31:1]};
            end

            if (count_ok) begin
                // The sequence advances from exp, never from the received word,
                // so one bad word does not cascade into later mismatches.
                exp_d  = (data_type == 32'd1) ? (exp_q - W'(1)) : (exp_q + W'(1));
                // A missing TLAST leaves wcnt growing so later words keep flagging.
                wcnt_d = S_AXIS_TLAST ? 32'd0 : (wcnt_q + NB32);
                rx_d   = rx_q + NB32;
                if (S_AXIS_TLAST) begin
                    pkt_d = pkt_next;
                end
                err_d = err_q + {31'd0, data_err} + {31'd0, last_err};
                if (data_err) begin
                    dseen_d = 1'b1;
                    if (!dseen_q) begin
                        fexp_d = exp_q;
                        fgot_d = S_AXIS_TDATA;
                    end
                end
                if (last_err) begin
                    lseen_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset dominates any command in the same cycle.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            rot_q    <= rdy_pattern;
            exp_q    <= '0;
            wcnt_q   <= '0;
            rx_q     <= '0;
            pkt_q    <= '0;
            err_q    <= '0;
            dseen_q  <= 1'b0;
            lseen_q  <= 1'b0;
            fexp_q   <= '0;
            fgot_q   <= '0;
        end else begin
            enable_q <= enable_d;
            done_q   <= done_d;
            rot_q    <= rot_d;
            exp_q    <= exp_d;
            wcnt_q   <= wcnt_d;
            rx_q     <= rx_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
            dseen_q  <= dseen_d;
            lseen_q  <= lseen_d;
            fexp_q   <= fexp_d;
            fgot_q   <= fgot_d;
        end
    end

    assign stat          = {28'h0, lseen_q, dseen_q, done_q, enable_q};
    assign rx_cnt        = rx_q;
    assign pkt_cnt       = pkt_q;
    assign err_cnt       = err_q;
    assign first_err_exp = fexp_q;
    assign first_err_got = fgot_q;

endmodule

// File: tb/tb_axis_dsnk_chk.sv
// tb_axis_dsnk_chk: scoreboard bench for axis_dsnk_chk. A behavioural model of
// the expected counter sequence and packet framing predicts the register
// state after every accepted word; a monitor compares on each transfer.
`timescale 1ns/1ps
module tb_axis_dsnk_chk;
    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid, tlast, new_cmd;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [31:0] cmd, num_bytes, data_type, num_pkts, rdy_pattern;

    logic        tready, tready_s;
    logic [31:0] stat, rx_cnt, pkt_cnt, err_cnt, fexp, fgot;
    logic [31:0] stat_s, rx_cnt_s, pkt_cnt_s, err_cnt_s, fexp_s, fgot_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axis_dsnk_chk #(.C_S_AXIS_TDATA_NUM_BYTES(NB), .C_ERR_STOP(0)) u_dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast), .S_AXIS_TREADY(tready),
        .cmd(cmd), .new_cmd(new_cmd), .num_bytes(num_bytes), .data_type(data_type),
        .num_pkts(num_pkts), .rdy_pattern(rdy_pattern),
        .stat(stat), .rx_cnt(rx_cnt), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
        .first_err_exp(fexp), .first_err_got(fgot)
    );

    axis_dsnk_chk #(.C_S_AXIS_TDATA_NUM_BYTES(NB), .C_ERR_STOP(1)) u_stop (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TVALID(tvalid), .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb),
        .S_AXIS_TLAST(tlast), .S_AXIS_TREADY(tready_s),
        .cmd(cmd), .new_cmd(new_cmd), .num_bytes(num_bytes), .data_type(data_type),
        .num_pkts(num_pkts), .rdy_pattern(rdy_pattern),
        .stat(stat_s), .rx_cnt(rx_cnt_s), .pkt_cnt(pkt_cnt_s), .err_cnt(err_cnt_s),
        .first_err_exp(fexp_s), .first_err_got(fgot_s)
    );

    typedef struct {
        logic [31:0] rx, pkt, err, st, fexp, fgot;
    } exp_t;
    exp_t sb[$];

    // Reference model state (words since clear, word index inside packet, ...)
    logic [31:0] m_n, m_rx, m_pkt, m_err, m_fexp, m_fgot;
    longint      m_pos;
    logic        m_dseen, m_lseen, m_en, m_done;
    logic [31:0] m_nb, m_dt, m_pkts;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] m_stat();
        return {28'h0, m_lseen, m_dseen, m_done, m_en};
    endfunction

    function automatic logic [31:0] model_exp();
        return (m_dt == 32'd1) ? (32'd0 - m_n) : m_n;
    endfunction

    function automatic bit model_last_exp();
        return ((m_pos + 1) * NB) >= longint'(m_nb);
    endfunction

    task automatic model_clear();
        m_n = 0; m_rx = 0; m_pkt = 0; m_err = 0; m_fexp = 0; m_fgot = 0;
        m_pos = 0; m_dseen = 0; m_lseen = 0; m_en = 0; m_done = 0;
    endtask

    // Apply one accepted word to the model and queue the predicted state.
    task automatic model_accept(input logic [31:0] d, input logic l);
        exp_t e;
        bit derr, lerr;
        derr = (d != model_exp());
        lerr = (l != model_last_exp());
        if (derr && !m_dseen) begin
            m_fexp = model_exp();
            m_fgot = d;
        end
        m_err = m_err + (derr ? 1 : 0) + (lerr ? 1 : 0);
        m_dseen = m_dseen | derr;
        m_lseen = m_lseen | lerr;
        m_n  = m_n + 1;
        m_rx = m_rx + NB;
        if (l) begin
            m_pkt = m_pkt + 1;
            m_pos = 0;
            if (m_pkts != 0 && m_pkt == m_pkts) begin
                m_done = 1;
                m_en   = 0;
            end
        end else begin
            m_pos = m_pos + 1;
        end
        e.rx = m_rx; e.pkt = m_pkt; e.err = m_err; e.st = m_stat();
        e.fexp = m_fexp; e.fgot = m_fgot;
        sb.push_back(e);
    endtask

    task automatic cfg(input logic [31:0] nb, input logic [31:0] dt,
                       input logic [31:0] pk, input logic [31:0] rp);
        num_bytes = nb; data_type = dt; num_pkts = pk; rdy_pattern = rp;
        m_nb = nb; m_dt = dt; m_pkts = pk;
    endtask

    // Called at posedge+1; the command takes effect on the following edge.
    task automatic do_cmd(input logic [31:0] c);
        cmd = c;
        new_cmd = 1'b1;
        @(posedge clk); #1;
        new_cmd = 1'b0;
        case (c)
            32'd1: if (!m_done) m_en = 1;
            32'd2: model_clear();
            32'd3: m_en = 0;
            default: ;
        endcase
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int  g;
        bit  fin;
        g = 0;
        fin = 0;
        tvalid = 1'b1; tdata = d; tlast = l;
        while (!fin) begin
            @(negedge clk);
            if (tready) begin
                model_accept(d, l);
                fin = 1;
            end else if (++g > 64) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: tready never rose for word %h", d);
                fin = 1;
            end
            @(posedge clk); #1;
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_rx"},   rx_cnt,  m_rx);
        chk({tag, "_pkt"},  pkt_cnt, m_pkt);
        chk({tag, "_err"},  err_cnt, m_err);
        chk({tag, "_stat"}, stat,    m_stat());
        chk({tag, "_fexp"}, fexp,    m_fexp);
        chk({tag, "_fgot"}, fgot,    m_fgot);
    endtask

    // Monitor: a transfer seen at a negedge lands on the next posedge and is
    // compared against the scoreboard at the negedge after that.
    initial begin
        bit   pend;
        exp_t e;
        pend = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: transfer with no predicted state");
                end else begin
                    e = sb.pop_front();
                    chk("sb_rx",   rx_cnt,  e.rx);
                    chk("sb_pkt",  pkt_cnt, e.pkt);
                    chk("sb_err",  err_cnt, e.err);
                    chk("sb_stat", stat,    e.st);
                    chk("sb_fexp", fexp,    e.fexp);
                    chk("sb_fgot", fgot,    e.fgot);
                end
                pend = 0;
            end
            if (!rst && tvalid && tready) pend = 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat, d, p;
        bit          l, le;
        rst = 1'b1; tvalid = 0; tlast = 0; tdata = 0; tstrb = 4'hF;
        cmd = 0; new_cmd = 0;
        cfg(32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF);
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", tready, 0);
        chk_state("rst");
        @(posedge clk); #1;

        // Three incrementing packets of 16 bytes, then automatic DONE.
        cfg(32'd16, 32'd0, 32'd3, 32'hFFFF_FFFF);
        do_cmd(1);
        for (int i = 0; i < 12; i++) send(32'(i), (i % 4) == 3);
        chk("t1_tready_done", tready, 0);
        chk("t1_stat", stat, 32'h2);
        chk("t1_pkt", pkt_cnt, 3);
        chk("t1_rx", rx_cnt, 48);
        chk("t1_err", err_cnt, 0);
        tvalid = 1'b1; tdata = 32'd12;
        repeat (3) @(posedge clk);
        #1 tvalid = 1'b0;
        chk("t1_no_extra", rx_cnt, 48);
        do_cmd(1);
        chk("t1_cmd1_ignored", stat, 32'h2);

        // Decrementing sequence wrapping through zero.
        do_cmd(2);
        chk_state("clr1");
        cfg(32'd8, 32'd1, 32'd2, 32'hFFFF_FFFF);
        do_cmd(1);
        send(32'h0, 0);
        send(32'hFFFF_FFFF, 1);
        send(32'hFFFF_FFFE, 0);
        send(32'hFFFF_FFFD, 1);
        chk("t2_err", err_cnt, 0);
        chk("t2_stat", stat, 32'h2);

        // Single corrupted word; later words still match.
        do_cmd(2);
        cfg(32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF);
        do_cmd(1);
        for (int i = 0; i < 16; i++) send((i == 5) ? 32'hDEAD : 32'(i), (i % 4) == 3);
        chk("t3_err", err_cnt, 1);
        chk("t3_stat", stat, 32'h5);
        chk("t3_fexp", fexp, 32'h5);
        chk("t3_fgot", fgot, 32'hDEAD);

        // Early TLAST, then a packet whose TLAST arrives one word late.
        do_cmd(2);
        cfg(32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF);
        do_cmd(1);
        pat = 32'b1000_0100;
        for (int i = 0; i < 8; i++) send(model_exp(), pat[i]);
        chk("t4_err", err_cnt, 2);
        chk("t4_stat", stat, 32'h9);
        chk("t4_pkt", pkt_cnt, 2);

        // Backpressure pattern with the source always valid.
        do_cmd(2);
        pat = 32'h5;
        cfg(32'd1000, 32'd0, 32'd0, pat);
        do_cmd(1);
        tvalid = 1'b1; tlast = 1'b0; tdata = model_exp();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("t5_tready_pat", tready, pat[i % 32]);
            if (tready) model_accept(tdata, 1'b0);
            @(posedge clk); #1;
            tdata = model_exp();
        end
        tvalid = 1'b0;
        chk("t5_rx", rx_cnt, 16);
        chk("t5_stat", stat, 32'h1);

        // Randomised framing, data corruption, length and backpressure.
        for (int r = 0; r < 3; r++) begin
            do_cmd(2);
            p = $urandom;
            if (p == 0) p = 32'h1;
            cfg(32'($urandom_range(1, 24)), 32'($urandom_range(0, 1)), 32'd0, p);
            do_cmd(1);
            for (int i = 0; i < 40; i++) begin
                d = model_exp();
                if ($urandom_range(0, 9) == 0) d = d ^ ($urandom | 32'h1);
                le = model_last_exp();
                l = le ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
                send(d, l);
            end
            @(posedge clk); #1;
            chk_state("rand");
        end

        // Disable mid-packet freezes everything; clear zeroes and restarts exp.
        do_cmd(2);
        cfg(32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF);
        do_cmd(1);
        send(model_exp(), 0);
        send(model_exp(), 0);
        do_cmd(3);
        chk("t7_tready_off", tready, 0);
        tvalid = 1'b1; tdata = model_exp();
        repeat (4) @(posedge clk);
        #1 tvalid = 1'b0;
        chk_state("dis");
        do_cmd(2);
        chk_state("clr2");
        do_cmd(1);
        send(32'h0, 0);
        chk("t7_exp_restart", err_cnt, 0);

        // Error-stop variant enters DONE on the first bad word.
        do_cmd(2);
        cfg(32'd64, 32'd0, 32'd0, 32'hFFFF_FFFF);
        do_cmd(1);
        send(32'h0, 0);
        send(32'h1, 0);
        send(32'hBAD, 0);
        chk("t8_stop_stat", stat_s, 32'h6);
        chk("t8_stop_tready", tready_s, 0);
        chk("t8_stop_err", err_cnt_s, 1);
        chk("t8_stop_fexp", fexp_s, 32'h2);
        chk("t8_stop_fgot", fgot_s, 32'hBAD);
        chk("t8_main_tready", tready, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
